// File: rtl/game_pkg.sv
// Shared types and playfield constants for the obstacle/game datapath.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    DONE   = 2'd2
  } obstacle_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle overlap test; sums are one bit wider
// than the coordinates so edges near the top of the range cannot wrap.
import game_pkg::*;

module rect_overlap (
  input  logic [COORD_W-1:0] a_x,
  input  logic [COORD_W-1:0] a_y,
  input  logic [COORD_W-1:0] a_w,
  input  logic [COORD_W-1:0] a_h,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic [COORD_W-1:0] b_w,
  input  logic [COORD_W-1:0] b_h,
  output logic               overlap
);

  logic [COORD_W:0] a_r, a_b, b_r, b_b;

  assign a_r = {1'b0, a_x} + {1'b0, a_w};
  assign a_b = {1'b0, a_y} + {1'b0, a_h};
  assign b_r = {1'b0, b_x} + {1'b0, b_w};
  assign b_b = {1'b0, b_y} + {1'b0, b_h};

  assign overlap = ({1'b0, a_x} < b_r) && ({1'b0, b_x} < a_r) &&
                   ({1'b0, a_y} < b_b) && ({1'b0, b_y} < a_b);

endmodule

// File: rtl/obstacle_scroller.sv
// One obstacle slot: scrolls a rectangle left once per frame and reports
// a single collision pulse per new overlap with the player.
import game_pkg::*;

module obstacle_scroller #(
  parameter int START_X = 640,
  parameter int Y_TOP   = 400,
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32,
  parameter int SPEED   = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ready,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] player_size,
  output logic [COORD_W-1:0] pos_x,
  output logic               active,
  output logic               collision,
  output logic               end_level
);

  localparam logic [COORD_W-1:0] START = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] STEP  = COORD_W'(SPEED);

  obstacle_state_t state;
  logic            overlap, overlap_q, overlap_prev;

  rect_overlap u_overlap (
    .a_x     (pos_x),
    .a_y     (COORD_W'(Y_TOP)),
    .a_w     (COORD_W'(WIDTH)),
    .a_h     (COORD_W'(HEIGHT)),
    .b_x     (player_x),
    .b_y     (player_y),
    .b_w     (player_size),
    .b_h     (player_size),
    .overlap (overlap)
  );

  // Dropping ready wins over everything except Reset, including a same-cycle tick.
  always_ff @(posedge Clk) begin
    if (Reset || !ready) begin
      state     <= IDLE;
      pos_x     <= START;
      active    <= 1'b0;
      end_level <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= SCROLL;
          active <= 1'b1;
        end
        SCROLL: begin
          if (frame_tick) begin
            if (pos_x < STEP) begin
              state     <= DONE;
              active    <= 1'b0;
              end_level <= 1'b1;
            end else begin
              pos_x <= pos_x - STEP;
            end
          end
        end
        DONE: begin
          active    <= 1'b0;
          end_level <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          pos_x     <= START;
          active    <= 1'b0;
          end_level <= 1'b0;
        end
      endcase
    end
  end

  // Two register stages give the collision pulse a fixed two-cycle latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overlap_q    <= 1'b0;
      overlap_prev <= 1'b0;
      collision    <= 1'b0;
    end else begin
      overlap_q    <= overlap && (state == SCROLL);
      overlap_prev <= overlap_q;
      collision    <= overlap_q && !overlap_prev;
    end
  end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller against a cycle-level reference model.
module tb_obstacle_scroller;

  localparam int START_X = 640;
  localparam int Y_TOP   = 400;
  localparam int WIDTH   = 32;
  localparam int HEIGHT  = 32;
  localparam int SPEED   = 4;

  logic       Clk = 1'b0;
  logic       Reset, ready, frame_tick;
  logic [9:0] player_x, player_y, player_size;
  logic [9:0] pos_x;
  logic       active, collision, end_level;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = idle, 1 = scrolling, 2 = finished.
  int m_st;
  int m_pos;
  bit ovh[3];   // overlap-while-scrolling at the last three clock edges, newest first

  obstacle_scroller #(
    .START_X(START_X), .Y_TOP(Y_TOP), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SPEED(SPEED)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ready(ready), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y), .player_size(player_size),
    .pos_x(pos_x), .active(active), .collision(collision), .end_level(end_level)
  );

  always #10 Clk = ~Clk;

  function automatic bit ref_overlap(int ox, int px, int py, int ps);
    return (ox < px + ps) && (px < ox + WIDTH) && (Y_TOP < py + ps) && (py < Y_TOP + HEIGHT);
  endfunction

  function automatic bit exp_coll();
    return ovh[1] && !ovh[2];
  endfunction

  // Advance one clock, update the model with the inputs held across the edge.
  task automatic step();
    bit ov;
    @(posedge Clk);
    ov = (m_st == 1) && ref_overlap(m_pos, player_x, player_y, player_size);
    if (Reset) begin
      m_st = 0; m_pos = START_X; ovh = '{0, 0, 0};
    end else begin
      ovh[2] = ovh[1]; ovh[1] = ovh[0]; ovh[0] = ov;
      if (!ready) begin
        m_st = 0; m_pos = START_X;
      end else if (m_st == 0) begin
        m_st = 1;
      end else if (m_st == 1 && frame_tick) begin
        if (m_pos < SPEED) m_st = 2;
        else m_pos = m_pos - SPEED;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; ready = 0; frame_tick = 0;
    step(); step();
    Reset = 0;
  endtask

  task automatic test_reset();
    Reset = 1; ready = 1; frame_tick = 1;
    player_x = 10'd0; player_y = 10'd0; player_size = 10'd1;
    step(); step();
    checks++;
    if (pos_x !== 10'(START_X) || active !== 1'b0 || end_level !== 1'b0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL reset: pos_x=%0d active=%b end=%b coll=%b required pos_x=%0d 0 0 0",
               pos_x, active, end_level, collision, START_X);
    end
    Reset = 0; ready = 0; frame_tick = 0;
    step();
  endtask

  task automatic test_full_run();
    do_reset();
    player_x = 10'd0; player_y = 10'd0; player_size = 10'd1;
    ready = 1; step();
    checks++;
    if (active !== 1'b1) begin
      errors++; $display("FAIL enter_scroll: active=%b required 1", active);
    end
    for (int t = 1; t <= 170; t++) begin
      frame_tick = 1; step(); frame_tick = 0;
      if (t == 160) begin
        checks++;
        if (pos_x !== 10'd0 || active !== 1'b1) begin
          errors++; $display("FAIL tick160: pos_x=%0d active=%b required 0 1", pos_x, active);
        end
      end
      if (t == 161) begin
        checks++;
        if (end_level !== 1'b1 || active !== 1'b0 || pos_x !== 10'd0) begin
          errors++;
          $display("FAIL tick161: end=%b active=%b pos_x=%0d required 1 0 0", end_level, active, pos_x);
        end
      end
      step();
    end
    checks++;
    if (pos_x !== 10'd0 || end_level !== 1'b1 || collision !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: pos_x=%0d end=%b coll=%b required 0 1 0", pos_x, end_level, collision);
    end
    ready = 0; step();
    checks++;
    if (end_level !== 1'b0 || pos_x !== 10'(START_X) || active !== 1'b0) begin
      errors++;
      $display("FAIL done_exit: end=%b pos_x=%0d active=%b required 0 %0d 0", end_level, pos_x, active, START_X);
    end
  endtask

  task automatic test_collision(input int py, input int exp_pulses);
    int pulses = 0;
    do_reset();
    player_x = 10'd600; player_y = 10'(py); player_size = 10'd16;
    ready = 1; step();
    for (int t = 1; t <= 45; t++) begin
      for (int c = 0; c < 2; c++) begin
        frame_tick = (c == 0);
        step();
        if (collision === 1'b1) pulses++;
        checks++;
        if (collision !== exp_coll() || pos_x !== 10'(m_pos)) begin
          errors++;
          $display("FAIL coll_y%0d t%0d: coll=%b pos_x=%0d required %b %0d",
                   py, t, collision, pos_x, exp_coll(), m_pos);
        end
        // Tick 7 lands on 612; the pulse appears on the cycle after the next tick edge.
        if (t == 8 && c == 0 && exp_pulses == 1) begin
          checks++;
          if (collision !== 1'b1) begin
            errors++; $display("FAIL coll_latency: coll=%b required 1", collision);
          end
        end
      end
    end
    frame_tick = 0;
    checks++;
    if (pulses != exp_pulses) begin
      errors++; $display("FAIL coll_count_y%0d: pulses=%0d required %0d", py, pulses, exp_pulses);
    end
  endtask

  task automatic test_ready_drop();
    do_reset();
    player_x = 10'd0; player_y = 10'd0; player_size = 10'd1;
    ready = 1; step();
    for (int t = 1; t <= 50; t++) begin
      frame_tick = 1; step(); frame_tick = 0;
    end
    checks++;
    if (pos_x !== 10'd440) begin
      errors++; $display("FAIL tick50: pos_x=%0d required 440", pos_x);
    end
    ready = 0; step();
    checks++;
    if (pos_x !== 10'(START_X) || active !== 1'b0) begin
      errors++; $display("FAIL drop: pos_x=%0d active=%b required %0d 0", pos_x, active, START_X);
    end
    frame_tick = 1; step(); frame_tick = 0;
    ready = 1; step();
    frame_tick = 1; step(); frame_tick = 0;
    checks++;
    if (pos_x !== 10'(START_X - SPEED) || active !== 1'b1) begin
      errors++; $display("FAIL restart: pos_x=%0d active=%b required %0d 1", pos_x, active, START_X - SPEED);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ready = 1; step();
    frame_tick = 1; step(); step();
    ready = 0; step();
    frame_tick = 0;
    checks++;
    if (pos_x !== 10'(START_X) || active !== 1'b0) begin
      errors++;
      $display("FAIL drop_with_tick: pos_x=%0d active=%b required %0d 0", pos_x, active, START_X);
    end
  endtask

  task automatic test_reset_in_done();
    do_reset();
    player_x = 10'd0; player_y = 10'd0; player_size = 10'd1;
    ready = 1; frame_tick = 1;
    for (int i = 0; i < 170; i++) step();
    checks++;
    if (end_level !== 1'b1) begin
      errors++; $display("FAIL reach_done: end=%b required 1", end_level);
    end
    Reset = 1; step();
    checks++;
    if (end_level !== 1'b0 || active !== 1'b0 || pos_x !== 10'(START_X) || collision !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: end=%b active=%b pos_x=%0d required 0 0 %0d", end_level, active, pos_x, START_X);
    end
    Reset = 0; frame_tick = 0; step();
    checks++;
    if (active !== 1'b1 || pos_x !== 10'(START_X)) begin
      errors++; $display("FAIL reenter: active=%b pos_x=%0d required 1 %0d", active, pos_x, START_X);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      Reset      = ($urandom_range(0, 399) == 0);
      ready      = ($urandom_range(0, 99) >= 2);
      frame_tick = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) begin
        player_x    = 10'($urandom_range(0, 660));
        player_y    = 10'($urandom_range(360, 450));
        player_size = 10'($urandom_range(1, 48));
      end
      step();
      checks++;
      if (pos_x !== 10'(m_pos) || active !== (m_st == 1) || end_level !== (m_st == 2) ||
          collision !== exp_coll()) begin
        errors++;
        $display("FAIL random c%0d: pos_x=%0d act=%b end=%b coll=%b required %0d %b %b %b",
                 i, pos_x, active, end_level, collision, m_pos, m_st == 1, m_st == 2, exp_coll());
      end
    end
    Reset = 0;
  endtask

  initial begin
    m_st = 0; m_pos = START_X; ovh = '{0, 0, 0};
    Reset = 1; ready = 0; frame_tick = 0;
    player_x = 10'd0; player_y = 10'd0; player_size = 10'd1;
    @(negedge Clk);
    test_reset();
    test_full_run();
    test_collision(400, 1);
    test_collision(100, 0);
    test_ready_drop();
    test_same_cycle();
    test_reset_in_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_scroller.md
# obstacle_scroller

Per-obstacle motion and collision unit sitting directly downstream of the level sequencer. One instance is built per obstacle slot. Each instance consumes that slot's `block_ready`/`rect_ready` bit and scrolls a rectangle leftward across the 640×480 playfield once per frame. It returns the collision pulse and the `end_level` flag that the sequencer consumes, and the obstacle position consumed by the colour mapper.

## Interface
- `START_X`, default 640: left-edge x at spawn, just off the right of the screen.
- `Y_TOP`, default 400: fixed top y of the obstacle.
- `WIDTH`, default 32: obstacle width in pixels, ≥1.
- `HEIGHT`, default 32: obstacle height in pixels, ≥1.
- `SPEED`, default 4: pixels moved per frame tick, 1..63.
- `Clk` in 1: system clock, 50 MHz. Single clock domain.
- `Reset` in 1: synchronous, active-high.
- `ready` in 1: slot enable from the sequencer. Level, not pulse.
- `frame_tick` in 1: one-`Clk` pulse per frame (vsync-derived).
- `player_x` in 10: player left edge.
- `player_y` in 10: player top edge.
- `player_size` in 10: player square side, ≥1.
- `pos_x` out 10: current obstacle left edge.
- `active` out 1: obstacle is drawable (state SCROLL).
- `collision` out 1: one-cycle pulse on a new player/obstacle overlap.
- `end_level` out 1: obstacle has exited the left edge. Level signal, held.

## Operation
- States: IDLE, SCROLL, DONE.
- IDLE
  - `pos_x` = `START_X`; `active` = 0; `end_level` = 0.
  - `ready` = 1 → SCROLL.
- SCROLL
  - `active` = 1.
  - On `frame_tick`: if `pos_x` < `SPEED` → DONE; otherwise `pos_x` ← `pos_x` − `SPEED`.
  - Unsigned arithmetic never wraps below 0.
- DONE
  - `active` = 0; `end_level` = 1; `pos_x` frozen.
- Any state, `ready` = 0 → IDLE next cycle, `pos_x` ← `START_X`. This handles sequencer restart after a collision.
- `ready` = 0 has priority over a `frame_tick` in the same cycle.
- Overlap is true when all of the following hold, using 11-bit sums so there is no overflow:
  - `pos_x` < `player_x` + `player_size`
  - `player_x` < `pos_x` + `WIDTH`
  - `Y_TOP` < `player_y` + `player_size`
  - `player_y` < `Y_TOP` + `HEIGHT`
- `overlap_q` is overlap AND (state == SCROLL), registered.
- `collision` = `overlap_q` AND NOT `overlap_prev`, i.e. a rising edge only. A sustained overlap yields exactly one pulse.

## Timing
- Reset values: state IDLE, `pos_x` = `START_X`, `active` 0, `collision` 0, `end_level` 0, `overlap_q`/`overlap_prev` 0.
- `ready` rises in cycle N → `active` = 1 in N+1. The first move happens on the first `frame_tick` strictly after N.
- `frame_tick` in cycle N → new `pos_x` (or DONE) visible in N+1.
- Overlap latency: inputs/`pos_x` change in cycle N → `collision` pulse in N+2.
- `frame_tick` while in IDLE or DONE is ignored.
- `ready` dropping in DONE → IDLE, `end_level` 0 in the next cycle.
- `Reset` mid-SCROLL → all reset values in the next cycle, regardless of `ready`. Re-entry to SCROLL requires `ready` sampled high after `Reset` is released.

## Structure
- Package `game_pkg`:
  - `obstacle_state_t` enum (IDLE, SCROLL, DONE).
  - `SCREEN_W` = 640, `SCREEN_H` = 480.
  - `COORD_W` = 10.
- One sub-module `rect_overlap`: combinational AABB test (two rectangles, 10-bit coordinates, 11-bit internal sums) → 1-bit overlap. It is reusable by the colour mapper and player bounds logic.
- Top holds the FSM, the `pos_x` register and the collision edge detector.

## Test plan
- Defaults, `ready` = 1, 160 ticks → `pos_x` = 0. Tick 161 → `end_level` = 1, `active` = 0. Further ticks leave `pos_x` = 0.
- Player at (600, 400), size 16. After tick 7 (`pos_x` = 612), `collision` pulses once, 2 cycles later. No further pulse through tick 9 (`pos_x` = 604). No pulse once `pos_x` ≤ 568.
- Player at (600, 100), size 16, full run → `collision` never asserts.
- `ready` dropped at tick 50 (`pos_x` = 440) → next cycle IDLE, `pos_x` = 640. Re-raising `ready` restarts from 640.
- `ready` falling and `frame_tick` in the same cycle → IDLE, `pos_x` = 640, no decrement.
- `Reset` asserted in DONE with `ready` held 1 → IDLE with reset values. SCROLL is entered the cycle after `Reset` releases.
